// File: rtl/echo_seq_ctrl.sv
// Control sequencer for the single-tap feedback echo datapath (s0 multiply, s1 add/clip, s2 delay FIFO + feedback multiply).
// Ports: pi_clk/pi_sreset_n, pi_feedback_delay, AXIS slave (pi_valid, pi_tlast, po_ready), AXIS master (po_valid, po_tlast, pi_ready),
//        datapath strobes (po_clk_en_s0/s1, po_we_en, po_rd_en, po_fifo_sreset, po_mux_sel), status (po_armed, po_delay_err).
module echo_seq_ctrl #(
  parameter int MEM_DEPTH = 4,
  parameter int CNT_WIDTH = $clog2(MEM_DEPTH + 1)
) (
  input  logic        pi_clk,
  input  logic        pi_sreset_n,
  input  logic [15:0] pi_feedback_delay,
  input  logic        pi_valid,
  input  logic        pi_tlast,
  output logic        po_ready,
  output logic        po_valid,
  output logic        po_tlast,
  input  logic        pi_ready,
  output logic        po_clk_en_s0,
  output logic        po_clk_en_s1,
  output logic        po_we_en,
  output logic        po_rd_en,
  output logic        po_fifo_sreset,
  output logic        po_mux_sel,
  output logic        po_armed,
  output logic        po_delay_err
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_WAIT,
    S_READ,
    S_ADD,
    S_OUT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(MEM_DEPTH);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] dq;         // delay latched at LOAD, clamped to MEM_DEPTH
  logic [CNT_WIDTH-1:0] cnt;        // samples written into the delay line this frame
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 armed;
  logic                 delay_err;
  logic                 tlast_q;
  logic                 wr_pend;    // set on entry to OUT so only the first OUT cycle writes
  logic                 over;
  logic [CNT_WIDTH-1:0] d_clamped;
  logic                 wr;

  assign over      = (pi_feedback_delay > 16'(MEM_DEPTH));
  assign d_clamped = over ? DEPTH_C : pi_feedback_delay[CNT_WIDTH-1:0];
  assign wr        = (state == S_OUT) && wr_pend && (dq != '0);
  // Saturating count; armed stays set once the line holds dq samples.
  assign cnt_inc   = (cnt == dq) ? cnt : cnt + 1'b1;

  assign po_armed     = armed;
  assign po_delay_err = delay_err;

  always_ff @(posedge pi_clk) begin
    if (!pi_sreset_n) begin
      state     <= S_LOAD;
      dq        <= '0;
      cnt       <= '0;
      armed     <= 1'b0;
      delay_err <= 1'b0;
      tlast_q   <= 1'b0;
      wr_pend   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_LOAD: begin
          dq        <= d_clamped;
          delay_err <= over;
          cnt       <= '0;
          armed     <= 1'b0;
        end
        S_WAIT: begin
          if (pi_valid) tlast_q <= pi_tlast;
        end
        S_ADD: begin
          wr_pend <= 1'b1;
        end
        S_OUT: begin
          wr_pend <= 1'b0;
          if (wr) begin
            cnt   <= cnt_inc;
            armed <= (cnt_inc == dq);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt      = state;
    po_ready       = 1'b0;
    po_valid       = 1'b0;
    po_tlast       = 1'b0;
    po_clk_en_s0   = 1'b0;
    po_clk_en_s1   = 1'b0;
    po_we_en       = 1'b0;
    po_rd_en       = 1'b0;
    po_fifo_sreset = 1'b0;
    po_mux_sel     = 1'b0;
    case (state)
      S_LOAD: begin
        po_fifo_sreset = 1'b1;
        state_nxt      = S_WAIT;
      end
      S_WAIT: begin
        po_ready = 1'b1;
        if (pi_valid) begin
          po_clk_en_s0 = 1'b1;
          po_rd_en     = armed;
          state_nxt    = S_READ;
        end
      end
      S_READ: begin
        po_mux_sel = armed;
        state_nxt  = S_ADD;
      end
      S_ADD: begin
        po_mux_sel   = armed;
        po_clk_en_s1 = 1'b1;
        state_nxt    = S_OUT;
      end
      S_OUT: begin
        po_valid = 1'b1;
        po_tlast = tlast_q;
        po_we_en = wr;
        if (pi_ready) state_nxt = tlast_q ? S_LOAD : S_WAIT;
      end
      default: state_nxt = S_LOAD;
    endcase
    // Reset held low silences every strobe, including the LOAD flush.
    if (!pi_sreset_n) begin
      po_ready       = 1'b0;
      po_valid       = 1'b0;
      po_tlast       = 1'b0;
      po_clk_en_s0   = 1'b0;
      po_clk_en_s1   = 1'b0;
      po_we_en       = 1'b0;
      po_rd_en       = 1'b0;
      po_fifo_sreset = 1'b0;
      po_mux_sel     = 1'b0;
    end
  end

endmodule

// File: tb/tb_echo_seq_ctrl.sv
// Bench for echo_seq_ctrl: behavioural echo datapath driven by the DUT strobes, reference echo model feeding a scoreboard.
// Ports: none.
module tb_echo_seq_ctrl;

  localparam int MEM = 4;
  localparam int G   = 16384;  // feedback gain 0.5 in Q15

  logic        clk;
  logic        pi_sreset_n;
  logic [15:0] pi_feedback_delay;
  logic        pi_valid, pi_tlast, pi_ready;
  logic        po_ready, po_valid, po_tlast;
  logic        po_clk_en_s0, po_clk_en_s1, po_we_en, po_rd_en;
  logic        po_fifo_sreset, po_mux_sel, po_armed, po_delay_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  echo_seq_ctrl #(.MEM_DEPTH(MEM)) dut (
    .pi_clk(clk), .pi_sreset_n(pi_sreset_n), .pi_feedback_delay(pi_feedback_delay),
    .pi_valid(pi_valid), .pi_tlast(pi_tlast), .po_ready(po_ready),
    .po_valid(po_valid), .po_tlast(po_tlast), .pi_ready(pi_ready),
    .po_clk_en_s0(po_clk_en_s0), .po_clk_en_s1(po_clk_en_s1), .po_we_en(po_we_en),
    .po_rd_en(po_rd_en), .po_fifo_sreset(po_fifo_sreset), .po_mux_sel(po_mux_sel),
    .po_armed(po_armed), .po_delay_err(po_delay_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int mulg(input int a);
    return (a * G) >>> 15;
  endfunction
  function automatic int clip(input int a);
    if (a > 32767) return 32767;
    if (a < -32768) return -32768;
    return a;
  endfunction

  // Behavioural datapath driven by the strobes.
  int x_in = 0;
  int s0_r = 0, s1_r = 0, s2_r = 0, fifo_q = 0;
  int fifo[$];
  always @(posedge clk) begin
    if (po_fifo_sreset) fifo.delete();
    else begin
      if (po_rd_en) begin
        n_checks++;
        if (fifo.size() == 0) begin
          n_fail++;
          $display("FAIL fifo_underflow: read with occupancy %0d, required >0", fifo.size());
          fifo_q <= 0;
        end else fifo_q <= fifo.pop_front();
      end
      if (po_we_en) begin
        n_checks++;
        if (fifo.size() >= MEM) begin
          n_fail++;
          $display("FAIL fifo_overflow: write with occupancy %0d, required <%0d", fifo.size(), MEM);
        end else fifo.push_back(s1_r);
      end
    end
    s2_r <= mulg(fifo_q);
    if (po_clk_en_s0) s0_r <= x_in;
    if (po_clk_en_s1) s1_r <= clip(s0_r + (po_mux_sel ? s2_r : 0));
  end

  // Reference echo model: y[n] = clip(x[n] + g*y[n-Dq]) within a frame.
  int ref_dq = 0;
  int hist[$];
  int sb[$];
  function automatic int ref_next(input int x);
    int fb, y;
    fb = (ref_dq > 0 && hist.size() >= ref_dq) ? mulg(hist[hist.size() - ref_dq]) : 0;
    y  = clip(x + fb);
    hist.push_back(y);
    return y;
  endfunction

  // Per-sample observations recorded by send().
  logic obs_rd, obs_mux_rd, obs_mux_add, obs_tlast;
  int   obs_we, obs_lat, obs_hold_bad, obs_acc_cyc, obs_y;

  task automatic send(input int x, input bit last, input int hold);
    int t, e;
    t = 0;
    while (po_ready !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    n_checks++;
    if (po_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_timeout: po_ready=%b after %0d cycles, required 1", po_ready, t);
      return;
    end
    x_in = x; pi_tlast = last; pi_valid = 1'b1;
    sb.push_back(ref_next(x));
    if (last) hist.delete();
    #1;
    obs_rd = po_rd_en; obs_acc_cyc = cyc;
    @(negedge clk);
    pi_valid = 1'b0; pi_tlast = 1'b0; x_in = 0;
    obs_lat = 1; obs_we = 0; obs_hold_bad = 0; obs_mux_rd = 1'bx; obs_mux_add = 1'bx;
    while (po_valid !== 1'b1 && obs_lat < 20) begin
      if (obs_lat == 1) obs_mux_rd = po_mux_sel;
      if (obs_lat == 2) obs_mux_add = po_mux_sel;
      obs_we += int'(po_we_en);
      @(negedge clk);
      obs_lat++;
    end
    n_checks++;
    if (po_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL valid_timeout: po_valid=%b after %0d cycles, required 1", po_valid, obs_lat);
      void'(sb.pop_front());
      return;
    end
    for (int i = 0; i < hold; i++) begin
      if (po_valid !== 1'b1 || po_tlast !== last || po_ready !== 1'b0) obs_hold_bad++;
      obs_we += int'(po_we_en);
      @(negedge clk);
    end
    obs_tlast = po_tlast;
    obs_we += int'(po_we_en);
    pi_ready = 1'b1;
    obs_y = s1_r;
    e = sb.pop_front();
    n_checks++;
    if (obs_y !== e) begin
      n_fail++;
      $display("FAIL sample_value: got %0d, required %0d", obs_y, e);
    end
    @(negedge clk);
    pi_ready = 1'b0;
  endtask

  task automatic reload(input int d);
    pi_feedback_delay = d[15:0];
    ref_dq = (d > MEM) ? MEM : d;
    hist.delete();
    pi_valid = 1'b0; pi_ready = 1'b0;
    pi_sreset_n = 1'b0;
    @(negedge clk);
    pi_sreset_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [10:0] all_outs();
    return {po_ready, po_valid, po_tlast, po_clk_en_s0, po_clk_en_s1, po_we_en,
            po_rd_en, po_fifo_sreset, po_mux_sel, po_armed, po_delay_err};
  endfunction

  task automatic test_reset;
    pi_sreset_n = 1'b0; pi_valid = 1'b1; pi_tlast = 1'b1; pi_ready = 1'b1; pi_feedback_delay = 16'd2;
    repeat (3) @(negedge clk);
    n_checks++;
    if (all_outs() !== 11'd0) begin n_fail++; $display("FAIL reset_outputs: got %b, required 0", all_outs()); end
    pi_valid = 1'b0; pi_tlast = 1'b0; pi_ready = 1'b0;
    pi_sreset_n = 1'b1;
    #1;
    n_checks++;
    if (po_fifo_sreset !== 1'b1 || po_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_load: fifo_sreset=%b ready=%b, required 1 0", po_fifo_sreset, po_ready);
    end
    @(negedge clk);
    n_checks++;
    if ({po_ready, po_fifo_sreset, po_armed, po_delay_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_wait: ready/sreset/armed/err=%b, required 1000",
               {po_ready, po_fifo_sreset, po_armed, po_delay_err});
    end
  endtask

  task automatic test_impulse;
    int first_rd;
    first_rd = 0;
    reload(2);
    for (int i = 1; i <= 8; i++) begin
      send((i == 1) ? 16384 : 0, i == 8, 0);
      if (obs_rd === 1'b1 && first_rd == 0) first_rd = i;
      if (i == 3) begin
        n_checks++;
        if (obs_y !== 8192) begin n_fail++; $display("FAIL impulse_echo3: got %0d, required 8192", obs_y); end
      end
      if (i == 5) begin
        n_checks++;
        if (obs_y !== 4096) begin n_fail++; $display("FAIL impulse_echo5: got %0d, required 4096", obs_y); end
      end
    end
    n_checks++;
    if (first_rd !== 3) begin n_fail++; $display("FAIL impulse_first_rd: sample %0d, required 3", first_rd); end
    n_checks++;
    if (po_delay_err !== 1'b0) begin n_fail++; $display("FAIL impulse_delay_err: got %b, required 0", po_delay_err); end
  endtask

  task automatic test_back_to_back;
    int prev;
    reload(2);
    prev = 0;
    for (int i = 1; i <= 6; i++) begin
      send(int'($urandom_range(0, 20000)) - 10000, i == 6, 0);
      n_checks++;
      if (obs_lat !== 3 || obs_we !== 1) begin
        n_fail++; $display("FAIL b2b_timing: sample %0d latency %0d we %0d, required 3 1", i, obs_lat, obs_we);
      end
      if (i > 1) begin
        n_checks++;
        if (obs_acc_cyc - prev !== 4) begin
          n_fail++; $display("FAIL b2b_spacing: sample %0d spacing %0d, required 4", i, obs_acc_cyc - prev);
        end
      end
      prev = obs_acc_cyc;
    end
  endtask

  task automatic test_backpressure;
    reload(2);
    send(3000, 1'b0, 0);
    send(-2000, 1'b0, 0);
    send(1000, 1'b1, 5);
    n_checks++;
    if (obs_hold_bad !== 0 || obs_tlast !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: unstable cycles %0d tlast %b, required 0 1", obs_hold_bad, obs_tlast);
    end
    n_checks++;
    if (obs_we !== 1) begin n_fail++; $display("FAIL bp_we: pulses %0d, required 1", obs_we); end
  endtask

  task automatic test_frame_boundary;
    reload(3);
    for (int i = 1; i <= 6; i++) begin
      if (i == 3) pi_feedback_delay = 16'd1;
      if (i == 6) pi_feedback_delay = 16'd3;
      send((i == 1) ? 12000 : 500 * i, i == 6, 0);
    end
    n_checks++;
    if (po_fifo_sreset !== 1'b1) begin n_fail++; $display("FAIL frame_sreset: got %b, required 1", po_fifo_sreset); end
    @(negedge clk);
    n_checks++;
    if (po_fifo_sreset !== 1'b0) begin n_fail++; $display("FAIL frame_sreset_pulse: got %b, required 0", po_fifo_sreset); end
    for (int i = 1; i <= 4; i++) begin
      send(2000, i == 4, 0);
      n_checks++;
      if (obs_mux_rd !== (i == 4) || obs_mux_add !== (i == 4)) begin
        n_fail++;
        $display("FAIL frame_mux: sample %0d mux %b%b, required %0d", i, obs_mux_rd, obs_mux_add, (i == 4));
      end
    end
  endtask

  task automatic test_clamp;
    reload(9);
    n_checks++;
    if (po_delay_err !== 1'b1) begin n_fail++; $display("FAIL clamp_err: got %b, required 1", po_delay_err); end
    for (int i = 1; i <= 6; i++) begin
      send((i == 1) ? 16384 : 100, i == 6, 0);
      n_checks++;
      if (po_armed !== (i >= 4) || obs_rd !== (i >= 5)) begin
        n_fail++;
        $display("FAIL clamp_arm: sample %0d armed %b rd %b, required %0d %0d", i, po_armed, obs_rd, (i >= 4), (i >= 5));
      end
    end
  endtask

  task automatic test_zero_delay;
    int strobes, mux_any;
    reload(0);
    strobes = 0; mux_any = 0;
    for (int i = 1; i <= 10; i++) begin
      send(1000 * i, i == 10, 0);
      strobes += int'(obs_rd) + obs_we;
      mux_any += int'(obs_mux_rd) + int'(obs_mux_add);
    end
    n_checks++;
    if (strobes !== 0 || mux_any !== 0 || po_armed !== 1'b0) begin
      n_fail++; $display("FAIL zero_delay: strobes %0d mux %0d armed %b, required 0 0 0", strobes, mux_any, po_armed);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    reload(2);
    x_in = 5000; pi_valid = 1'b1;
    @(negedge clk);
    pi_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (po_clk_en_s1 !== 1'b1) begin n_fail++; $display("FAIL rst_mid_add: clk_en_s1=%b, required 1", po_clk_en_s1); end
    pi_sreset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (all_outs() !== 11'd0) begin n_fail++; $display("FAIL rst_mid_outputs: got %b, required 0", all_outs()); end
    pi_sreset_n = 1'b1;
    #1;
    n_checks++;
    if (po_fifo_sreset !== 1'b1) begin n_fail++; $display("FAIL rst_mid_load: got %b, required 1", po_fifo_sreset); end
    seen = 0;
    repeat (4) begin @(negedge clk); seen += int'(po_valid); end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_no_valid: valid cycles %0d, required 0", seen); end
    hist.delete();
    send(7000, 1'b1, 0);
    n_checks++;
    if (obs_lat !== 3) begin n_fail++; $display("FAIL rst_mid_resume: latency %0d, required 3", obs_lat); end
  endtask

  initial begin
    pi_sreset_n = 1'b0; pi_valid = 1'b0; pi_tlast = 1'b0; pi_ready = 1'b0; pi_feedback_delay = 16'd0;
    @(negedge clk);
    test_reset;
    test_impulse;
    test_back_to_back;
    test_backpressure;
    test_frame_boundary;
    test_clamp;
    test_zero_delay;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule
